display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits (1..8).
REQ-002 Parameter VALUE_W, default 8: width of value inputs. Legal only if 2^VALUE_W - 1 < 10^NUM_DIGITS.
REQ-003 Parameter SCAN_DIV, default 1000: clocks per digit slot (>=2).
REQ-004 Parameter BLINK_FRAMES, default 64: full scan frames per error-blink phase (>=1).
REQ-005 Parameter LZ_BLANK, default 1: 1 = blank leading zeros (digit0 never blanked).
REQ-006 Port clk, in, 1: single clock, rising edge.
REQ-007 Port rst_n, in, 1: asynchronous, active-low reset.
REQ-008 Port credit, in, VALUE_W: inserted credit.
REQ-009 Port price, in, VALUE_W: selected item price.
REQ-010 Port change_due, in, VALUE_W: change owed.
REQ-011 Port state, in, 3: vending FSM state (0=IDLE, 5=ERROR, 6=DONE).
REQ-012 Port an, out, NUM_DIGITS: active-low digit enables, bit i = digit i (digit0 = least significant).
REQ-013 Port seg, out, 7: active-low segments, order {g,f,e,d,c,b,a}.
REQ-014 Port busy, out, 1: high while the BCD converter runs.

Function
REQ-015 Source select: IDLE -> credit; ERROR -> text "Err"; DONE -> change_due if nonzero, else text "donE"; other states -> price if nonzero, else credit.
REQ-016 Text occupies the most-significant digits left-justified; remaining digits are blank; text is truncated on the right if NUM_DIGITS < text length.
REQ-017 Converter FSM states: IDLE, SHIFT. It is sequential double-dabble with one shift per clock.
REQ-018 In IDLE, the converter loads and enters SHIFT when the selected numeric value differs from its last-converted snapshot, or when no conversion has completed since reset.
REQ-019 busy is high for exactly VALUE_W cycles per conversion.
REQ-020 The BCD digit register is updated atomically on the cycle busy falls; digits shown before that update hold their previous values.
REQ-021 Input changes during SHIFT are ignored. The comparison is re-evaluated in IDLE, so a changed value starts its conversion on the cycle after completion.
REQ-022 Text modes bypass the converter and take effect on the next clock.
REQ-023 Scan: a divider counts 0..SCAN_DIV-1. On wrap, the digit index advances and wraps from NUM_DIGITS-1 to 0. an is one-hot-low at the index.
REQ-024 The frame counter increments when the digit index wraps to 0. The blink phase toggles every BLINK_FRAMES frames.
REQ-025 In ERROR with blink phase 1, an is all ones. Blink phase and counters free-run in all states.
REQ-026 seg and an are registered, with one clock of latency from index/digit change.
REQ-027 Codes, as hex of {g..a} active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, E=06, r=2F, d=21, o=23, n=2B, blank=7F.
REQ-028 With LZ_BLANK=1, zero digits above the highest nonzero digit display blank. A value of 0 shows a single 0 in digit0.

Reset
REQ-029 While rst_n=0: an all ones, seg=7F, busy=0, divider/index/frame/blink phase=0, digit register all blank, snapshot invalid.
REQ-030 When rst_n is asserted mid-conversion, the conversion aborts immediately. After release, a fresh conversion starts on the first clock edge.

Verification (NUM_DIGITS=4, VALUE_W=8, SCAN_DIV=4, BLINK_FRAMES=2, LZ_BLANK=1)
REQ-031 Reset, then release with state=0 and credit=0: during reset an=F and seg=7F. After release, busy is high for 8 cycles, then digit0 shows 40 and digits 1-3 show 7F.
REQ-032 Scenario: state=0, credit=125. Required response: busy pulses high for 8 cycles, then the scan shows digit0=12, digit1=24, digit2=79, digit3=7F. Each digit is held 4 clocks, in an order E,D,B,7.
REQ-033 Scenario: state=3, price=200, then price=0 with credit=50. Required response: the display shows "200" (digit2=24, digit1=40, digit0=40), then "50".
REQ-034 Scenario: state=5. Required response: digit3..0 = 06,2F,2F,7F. an is forced to F for 32-clock windows, alternating with 32-clock windows of normal scan.
REQ-035 Scenario: state=6, change_due=0, then change_due=35. Required response: the display shows "donE" (21,23,2B,06), then "35" after a busy pulse.
REQ-036 Scenario: change credit 10 -> 99 on the 3rd busy cycle. Required response: "10" is displayed, then a second 8-cycle conversion yields "99". Asserting rst_n low mid-conversion immediately yields the REQ-029 values.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment display controller for a vending machine front panel.
// Chooses a numeric value or a text message from the vending state, converts
// numbers to BCD with a one-shift-per-clock double-dabble, scans the digits
// and blinks the whole display while in the ERROR state.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int VALUE_W      = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter int LZ_BLANK     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VALUE_W-1:0]    credit,
  input  logic [VALUE_W-1:0]    price,
  input  logic [VALUE_W-1:0]    change_due,
  input  logic [2:0]            state,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  busy
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int CNT_W   = $clog2(VALUE_W + 1);
  localparam int DIV_W   = $clog2(SCAN_DIV);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [2:0] VS_IDLE  = 3'd0;
  localparam logic [2:0] VS_ERROR = 3'd5;
  localparam logic [2:0] VS_DONE  = 3'd6;

  // Nibble value that the digit register uses to mean "blank digit".
  localparam logic [3:0] BLANK_NIB = 4'hF;

  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_O     = 7'h23;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {CONV_IDLE, CONV_SHIFT} conv_state_e;

  // Decimal digit to active-low segment pattern; anything else shows blank.
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Text character at position pos counted from the most significant digit;
  // positions past the end of the message are blank, so narrow displays truncate.
  function automatic logic [6:0] text_seg(input logic is_done, input int pos);
    logic [6:0] s;
    s = SEG_BLANK;
    if (is_done) begin
      case (pos)
        0:       s = SEG_D;
        1:       s = SEG_O;
        2:       s = SEG_N;
        3:       s = SEG_E;
        default: s = SEG_BLANK;
      endcase
    end else begin
      case (pos)
        0:       s = SEG_E;
        1, 2:    s = SEG_R;
        default: s = SEG_BLANK;
      endcase
    end
    return s;
  endfunction

  conv_state_e              conv_q, conv_d;
  logic [VALUE_W-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]         bcd_q, bcd_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [VALUE_W-1:0]       snap_q, snap_d;
  logic                     snap_vld_q, snap_vld_d;
  logic [BCD_W-1:0]         digits_q, digits_d;
  logic [BCD_W-1:0]         bcd_adj, bcd_shift, digits_fmt;
  logic                     seen_nz;
  logic [VALUE_W-1:0]       sel_val;
  logic                     text_mode, text_done;
  logic [DIV_W-1:0]         div_q;
  logic [IDX_W-1:0]         idx_q;
  logic [FRAME_W-1:0]       frame_q;
  logic                     blink_q;
  logic [NUM_DIGITS-1:0]    an_q, an_d;
  logic [6:0]               seg_q, seg_d;

  // Pick what the panel should show for the current vending state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sel_val   = credit;
    text_mode = 1'b0;
    text_done = 1'b0;
    case (state)
      VS_IDLE:  sel_val = credit;
      VS_ERROR: text_mode = 1'b1;
      VS_DONE: begin
        if (change_due != '0) begin
          sel_val = change_due;
        end else begin
          text_mode = 1'b1;
          text_done = 1'b1;
        end
      end
      default:  sel_val = (price != '0) ? price : credit;
    endcase
  end

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[VALUE_W-1]};
  end

  // Leading-zero blanking of the finished result, scanning from the top digit down.
  always_comb begin
    seen_nz    = 1'b0;
    digits_fmt = bcd_shift;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (bcd_shift[4*i +: 4] != 4'd0) begin
        seen_nz = 1'b1;
      end else if ((LZ_BLANK != 0) && !seen_nz && (i != 0)) begin
        digits_fmt[4*i +: 4] = BLANK_NIB;
      end
    end
  end

  // Converter next state: load on a new value, shift VALUE_W times, then publish.
  always_comb begin
    conv_d     = conv_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    digits_d   = digits_q;
    case (conv_q)
      CONV_IDLE: begin
        if (!text_mode && (!snap_vld_q || (sel_val != snap_q))) begin
          conv_d = CONV_SHIFT;
          bin_d  = sel_val;
          bcd_d  = '0;
          cnt_d  = '0;
          snap_d = sel_val;
        end
      end
      CONV_SHIFT: begin
        bcd_d = bcd_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(VALUE_W - 1)) begin
          conv_d     = CONV_IDLE;
          digits_d   = digits_fmt;
          snap_vld_d = 1'b1;
        end
      end
      default: conv_d = CONV_IDLE;
    endcase
  end

  // Converter state register; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      conv_q     <= CONV_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      // NOTE: the digit register is a handful of flops, so it is reset to blank rather than left undefined.
      digits_q   <= {NUM_DIGITS{BLANK_NIB}};
    end else begin
      conv_q     <= conv_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
      digits_q   <= digits_d;
    end
  end

  // Free-running scan divider, digit index, frame counter and blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
    end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_q <= '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_q <= '0;
        if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_q <= '0;
          blink_q <= ~blink_q;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Digit enable and segment pattern for the digit currently being scanned.
  always_comb begin
    an_d = ~(NUM_DIGITS'(1) << idx_q);
    if ((state == VS_ERROR) && blink_q) an_d = '1;
    if (text_mode) seg_d = text_seg(text_done, NUM_DIGITS - 1 - int'(idx_q));
    else           seg_d = digit_seg(digits_q[4*int'(idx_q) +: 4]);
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign busy = (conv_q == CONV_SHIFT);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with a small scan configuration.
// The reference model derives digit patterns with decimal arithmetic and the
// scan position from the number of clock edges since reset release.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cr, pr, ch;
  logic [2:0] st;
  logic [3:0] an;
  logic [6:0] seg;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  display_scan_ctrl #(
    .NUM_DIGITS(4), .VALUE_W(8), .SCAN_DIV(4), .BLINK_FRAMES(2), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .credit(cr), .price(pr), .change_due(ch),
    .state(st), .an(an), .seg(seg), .busy(busy)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; drives the scan-position model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dec_code(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] char_code(input byte c);
    case (c)
      "E": return 7'h06;  "r": return 7'h2F;  "d": return 7'h21;
      "o": return 7'h23;  "n": return 7'h2B;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected pattern of all four digits (digit i at bits [7i +: 7]).
  function automatic logic [27:0] expected_codes(input int s, input int c, input int p, input int d);
    logic [27:0] codes;
    string txt;
    int v, pos, pw;
    txt = "";
    v = 0;
    if (s == 5) txt = "Err";
    else if (s == 6 && d == 0) txt = "donE";
    else if (s == 0) v = c;
    else if (s == 6) v = d;
    else v = (p != 0) ? p : c;
    for (int i = 0; i < 4; i++) begin
      pw = 10 ** i;
      if (txt.len() != 0) begin
        pos = 3 - i;
        codes[7*i +: 7] = (pos < txt.len()) ? char_code(txt[pos]) : 7'h7F;
      end else if (i == 0 || v >= pw) begin
        codes[7*i +: 7] = dec_code((v / pw) % 10);
      end else begin
        codes[7*i +: 7] = 7'h7F;
      end
    end
    return codes;
  endfunction

  // Compare an/seg against the model for n consecutive cycles.
  task automatic check_window(input string tag, input int n, input logic [27:0] codes);
    int k, idx;
    logic [3:0] exp_an;
    for (int c = 0; c < n; c++) begin
      k = edges;
      idx = ((k - 1) / 4) % 4;
      exp_an = ~(4'b0001 << idx);
      if (st == 3'd5 && (((k - 1) / 32) % 2) == 1) exp_an = 4'hF;
      check({tag, "_an"}, 32'(an), 32'(exp_an));
      check({tag, "_seg"}, 32'(seg), 32'(codes[7*idx +: 7]));
      @(negedge clk);
    end
  endtask

  // Let any conversion triggered by new inputs finish and the outputs settle.
  task automatic settle();
    int guard;
    repeat (2) @(negedge clk);
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("settle_busy", 32'(busy), 32'(0));
    @(negedge clk);
  endtask

  task automatic show(input string tag, input int n);
    settle();
    check_window(tag, n, expected_codes(st, cr, pr, ch));
  endtask

  // Count the busy pulse that should begin on the next clock edge.
  task automatic measure_busy(input string tag);
    int n;
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'(8));
  endtask

  task automatic wait_busy_rise(input string tag);
    int guard;
    guard = 0;
    while (busy !== 1'b1 && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 32'(busy), 32'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  function automatic logic [7:0] rnd_val();
    if ($urandom_range(3) == 0) return 8'd0;
    return 8'($urandom_range(255));
  endfunction

  initial begin
    rst_n = 1'b0;
    st = 3'd0; cr = 8'd0; pr = 8'd0; ch = 8'd0;

    // Reset values, then first conversion of credit=0.
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    measure_busy("first_busy_len");
    show("zero", 16);

    // Credit 125 shows 125 with digit3 blank, scanned E,D,B,7.
    cr = 8'd125;
    measure_busy("busy_125");
    show("credit125", 16);

    // Vending state with a price, then with price 0 falls back to credit.
    st = 3'd3; pr = 8'd200;
    show("price200", 16);
    pr = 8'd0; cr = 8'd50;
    show("credit50", 16);

    // ERROR text with blinking: window spans both blink phases.
    st = 3'd5;
    show("err", 70);

    // DONE with no change shows text, then change due 35.
    st = 3'd6; ch = 8'd0;
    show("done_txt", 16);
    ch = 8'd35;
    measure_busy("busy_35");
    show("change35", 16);

    // Input change during conversion is ignored, then converted afterwards.
    st = 3'd0; cr = 8'd77;
    show("credit77", 4);
    cr = 8'd10;
    wait_busy_rise("busy_10_rise");
    repeat (2) @(negedge clk);
    cr = 8'd99;
    repeat (6) @(negedge clk);
    check("gap_busy", 32'(busy), 32'(0));
    @(negedge clk);
    check("second_busy", 32'(busy), 32'(1));
    check_window("shows10", 6, expected_codes(0, 10, 0, 0));
    show("credit99", 16);

    // Reset asserted mid-conversion aborts it; a fresh conversion follows release.
    cr = 8'd42;
    wait_busy_rise("busy_42_rise");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    repeat (2) @(negedge clk);
    check_reset_values("midreset_hold");
    rst_n = 1'b1;
    measure_busy("busy_after_reset");
    show("credit42", 16);

    // Randomized states and values against the model.
    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(4))
        0:       st = 3'd0;
        1:       st = 3'd1;
        2:       st = 3'd3;
        3:       st = 3'd5;
        default: st = 3'd6;
      endcase
      cr = rnd_val(); pr = rnd_val(); ch = rnd_val();
      show("rand", (st == 3'd5) ? 70 : 16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
